// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared types and constants for the PLL reset sequencer
package pll_reset_pkg;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_SYS   = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_e;

    // Width of the saturating lock-loss event counter
    localparam int LOST_W = 8;

    // Largest value the lock-loss counter can hold before it saturates
    localparam logic [LOST_W-1:0] LOST_MAX = {LOST_W{1'b1}};

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// rtl/pll_reset_sequencer_lock_sync.sv - 2-FF synchroniser, async active-low reset to 0
module lock_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - lock-qualified staggered reset release and VDP clock-enable
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int LOCK_WAIT = 1024,
    parameter int STAGGER   = 16,
    parameter int CE_DIV    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_lock,
    output logic              sys_reset_n,
    output logic              vdp_reset_n,
    output logic              ce,
    output logic              ready,
    output logic [LOST_W-1:0] lock_lost_count
);

    // Counters are at least one bit wide even when the parameter is 1
    localparam int WAIT_W = $clog2((LOCK_WAIT > 2) ? LOCK_WAIT : 2);
    localparam int STAG_W = $clog2((STAGGER > 2) ? STAGGER : 2);
    localparam int CE_W   = $clog2((CE_DIV > 2) ? CE_DIV : 2);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_WAIT - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [CE_W-1:0]   CE_LAST   = CE_W'(CE_DIV - 1);

    logic lock_s;

    seq_state_e        state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [STAG_W-1:0] stag_cnt_q;
    logic [CE_W-1:0]   ce_cnt_q;
    logic [CE_W-1:0]   ce_cnt_d;
    logic [LOST_W-1:0] lost_cnt_q;
    logic [LOST_W-1:0] lost_cnt_d;
    logic              sys_rst_n_q;
    logic              vdp_rst_n_q;
    logic              ce_q;
    logic              ready_q;

    lock_sync u_lock_sync (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .async_i (pll_lock),
        .sync_o  (lock_s)
    );

    // Next values for the wrapping CE divider and the saturating loss counter
    always_comb begin
        ce_cnt_d   = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + 1'b1;
        lost_cnt_d = (lost_cnt_q == LOST_MAX) ? lost_cnt_q : lost_cnt_q + 1'b1;
    end

    // Sequencer FSM: lock qualification, staggered release, CE generation, loss handling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT;
            wait_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            ce_cnt_q    <= '0;
            lost_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            vdp_rst_n_q <= 1'b0;
            ce_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            // Idle until the synchronised lock flag is seen high
            wait_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            ce_cnt_q    <= '0;
            sys_rst_n_q <= 1'b0;
            vdp_rst_n_q <= 1'b0;
            ce_q        <= 1'b0;
            ready_q     <= 1'b0;
            if (lock_s) begin
                state_q <= ST_COUNT;
            end
        end else if (!lock_s) begin
            // Any sampled loss of lock outside ST_WAIT restarts everything
            state_q     <= ST_WAIT;
            wait_cnt_q  <= '0;
            stag_cnt_q  <= '0;
            ce_cnt_q    <= '0;
            lost_cnt_q  <= lost_cnt_d;
            sys_rst_n_q <= 1'b0;
            vdp_rst_n_q <= 1'b0;
            ce_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_q     <= ST_SYS;
                        wait_cnt_q  <= '0;
                        stag_cnt_q  <= '0;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 1'b1;
                    end
                end
                ST_SYS: begin
                    if (stag_cnt_q == STAG_LAST) begin
                        state_q     <= ST_RUN;
                        stag_cnt_q  <= '0;
                        ce_cnt_q    <= '0;
                        vdp_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                        // A divide-by-one enable is already active in the first run cycle
                        ce_q        <= (CE_LAST == '0);
                    end else begin
                        stag_cnt_q  <= stag_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    // ce tracks the divider reaching its last count in the same cycle
                    ce_cnt_q <= ce_cnt_d;
                    ce_q     <= (ce_cnt_d == CE_LAST);
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign sys_reset_n     = sys_rst_n_q;
    assign vdp_reset_n     = vdp_rst_n_q;
    assign ce              = ce_q;
    assign ready           = ready_q;
    assign lock_lost_count = lost_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int LW = 8;
    localparam int ST = 4;
    localparam int CD = 4;
    localparam int NVEC = 30;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       sys_reset_n;
    logic       vdp_reset_n;
    logic       ce;
    logic       ready;
    logic [7:0] lock_lost_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic lock;
        logic sys;
        logic vdp;
        logic rdy;
        logic ce;
    } vec_t;

    vec_t tbl [NVEC];

    pll_reset_sequencer #(
        .LOCK_WAIT (LW),
        .STAGGER   (ST),
        .CE_DIV    (CD)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pll_lock        (pll_lock),
        .sys_reset_n     (sys_reset_n),
        .vdp_reset_n     (vdp_reset_n),
        .ce              (ce),
        .ready           (ready),
        .lock_lost_count (lock_lost_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Clean-lock vectors: entry k is the lock input sampled at edge k and the
        // outputs expected just after that edge. sys after edge 10, vdp/ready after
        // edge 14 (cycle R), ce in R+3, R+7, ... i.e. after edges 17, 21, 25, 29.
        for (int k = 0; k < NVEC; k++) begin
            tbl[k].lock = 1'b1;
            tbl[k].sys  = (k >= 10);
            tbl[k].vdp  = (k >= 14);
            tbl[k].rdy  = (k >= 14);
            tbl[k].ce   = (k >= 17) && (((k - 17) % 4) == 0);
        end

        // Reset hold with lock asserted
        reset_n  = 1'b0;
        pll_lock = 1'b1;
        step(20);
        chk("hold_sys", sys_reset_n, 0);
        chk("hold_vdp", vdp_reset_n, 0);
        chk("hold_ce", ce, 0);
        chk("hold_ready", ready, 0);
        chk("hold_count", lock_lost_count, 0);

        pll_lock = 1'b0;
        step(1);
        reset_n = 1'b1;
        step(4);
        chk("idle_sys", sys_reset_n, 0);
        chk("idle_ready", ready, 0);

        // Clean lock, table driven
        for (int k = 0; k < NVEC; k++) begin
            pll_lock = tbl[k].lock;
            step(1);
            chk($sformatf("clean_sys_e%0d", k), sys_reset_n, tbl[k].sys);
            chk($sformatf("clean_vdp_e%0d", k), vdp_reset_n, tbl[k].vdp);
            chk($sformatf("clean_rdy_e%0d", k), ready, tbl[k].rdy);
            chk($sformatf("clean_ce_e%0d", k), ce, tbl[k].ce);
        end
        chk("clean_count", lock_lost_count, 0);

        // Loss in ST_RUN for 5 sampled cycles
        pll_lock = 1'b0;
        step(2);
        chk("runloss_ready_e1", ready, 1);
        step(1);
        chk("runloss_ready_e2", ready, 0);
        chk("runloss_sys_e2", sys_reset_n, 0);
        chk("runloss_vdp_e2", vdp_reset_n, 0);
        chk("runloss_ce_e2", ce, 0);
        chk("runloss_count", lock_lost_count, 1);
        step(2);
        pll_lock = 1'b1;
        step(10);
        chk("relock_sys_e9", sys_reset_n, 0);
        step(1);
        chk("relock_sys_e10", sys_reset_n, 1);

        // Async reset while in ST_SYS, between clock edges
        step(1);
        chk("sys_state_sys", sys_reset_n, 1);
        chk("sys_state_vdp", vdp_reset_n, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_sys", sys_reset_n, 0);
        chk("async_count", lock_lost_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(10);
        chk("restart_sys_e9", sys_reset_n, 0);
        step(1);
        chk("restart_sys_e10", sys_reset_n, 1);

        // Loss in ST_COUNT observed by the FSM while wait_cnt=5
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(3);
        chk("count_pre", lock_lost_count, 0);
        for (int e = 0; e < 18; e++) begin
            pll_lock = (e == 6) ? 1'b0 : 1'b1;
            step(1);
            chk($sformatf("cntloss_sys_e%0d", e), sys_reset_n, (e >= 17) ? 1 : 0);
            if (e == 8) chk("cntloss_count", lock_lost_count, 1);
        end

        // Saturation of the lock-loss counter
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            step(4);
            pll_lock = 1'b1;
            step(4);
            if (i == 99) chk("sat_count_101", lock_lost_count, 101);
        end
        chk("sat_count_255", lock_lost_count, 255);
        for (int i = 0; i < 10; i++) begin
            pll_lock = 1'b0;
            step(4);
            pll_lock = 1'b1;
            step(4);
        end
        chk("sat_count_hold", lock_lost_count, 255);
        chk("sat_sys", sys_reset_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
